// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back datapath.
// Captures the MEM-stage result, aligns/extends load data, picks the
// write-back source, drives the register-file write port and counts
// instructions leaving WB.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_wreg,
  input  logic [1:0]        in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_addr_lo,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [DATA_W-1:0] in_pc,
  output logic              RegWrite,
  output logic [REG_AW-1:0] w,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] wb_pc,
  output logic              wb_valid,
  output logic [31:0]       retired_cnt
);

  // Write-back source select; the reserved code falls back to the ALU.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10
  } wb_sel_e;

  // Load width/extension; unknown codes behave as LW.
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_H  = 3'b001,
    LD_HU = 3'b010,
    LD_B  = 3'b011,
    LD_BU = 3'b100
  } ld_type_e;

  // Everything the stage carries from MEM into WB.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] wreg;
    logic [1:0]        mem_to_reg;
    logic [2:0]        load_type;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pc;
  } stage_t;

  stage_t            stg_q, stg_d;
  logic [31:0]       cnt_q;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] link_val;

  // Next stage contents: flush beats stall beats capture. A flush clears
  // every field so a bubble never leaks stale w/wdata onto the outputs.
  always_comb begin
    stg_d = stg_q;
    if (flush) begin
      stg_d = '0;
    end else if (!stall) begin
      stg_d.valid      = in_valid;
      stg_d.reg_write  = in_reg_write;
      stg_d.wreg       = in_wreg;
      stg_d.mem_to_reg = in_mem_to_reg;
      stg_d.load_type  = in_load_type;
      stg_d.addr_lo    = in_addr_lo;
      stg_d.alu_result = in_alu_result;
      stg_d.mem_rdata  = in_mem_rdata;
      stg_d.pc         = in_pc;
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stg_q <= '0;
    else     stg_q <= stg_d;
  end

  // Retire counter: an instruction leaves WB on any non-stalled edge,
  // including a flushing one; bubbles are never counted. Wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt_q <= '0;
    else if (stg_q.valid && !stall) cnt_q <= cnt_q + 32'd1;
  end

  // Little-endian lane pick for sub-word loads.
  always_comb begin
    ld_byte = stg_q.mem_rdata[{stg_q.addr_lo, 3'b000} +: 8];
    ld_half = stg_q.mem_rdata[{stg_q.addr_lo[1], 4'b0000} +: 16];
  end

  // Width/extension of the loaded value.
  always_comb begin
    ld_val = stg_q.mem_rdata;
    case (ld_type_e'(stg_q.load_type))
      LD_H:    ld_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LD_HU:   ld_val = {{(DATA_W-16){1'b0}}, ld_half};
      LD_B:    ld_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LD_BU:   ld_val = {{(DATA_W-8){1'b0}}, ld_byte};
      default: ld_val = stg_q.mem_rdata;
    endcase
  end

  // Return address for link instructions, modulo 2^DATA_W.
  always_comb link_val = stg_q.pc + DATA_W'(8);

  // Write-back source mux.
  always_comb begin
    wdata = stg_q.alu_result;
    case (wb_sel_e'(stg_q.mem_to_reg))
      WB_LOAD: wdata = ld_val;
      WB_LINK: wdata = link_val;
      default: wdata = stg_q.alu_result;
    endcase
  end

  // Register-file port and debug outputs; $0 is never written.
  always_comb begin
    RegWrite    = stg_q.valid & stg_q.reg_write & (stg_q.wreg != '0);
    w           = stg_q.wreg;
    wb_pc       = stg_q.pc;
    wb_valid    = stg_q.valid;
    retired_cnt = cnt_q;
  end

endmodule
